// File: rtl/opb_register_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : opb_register_bank_if
// Description : OPB slave-side bus bundle for opb_register_bank. The vectors
//               keep the OPB big-endian numbering: bit 0 is the MSB, so
//               DBus[0:7] is the most significant byte lane and BE[0]
//               qualifies it.
// Ports       : master modport drives OPB_* and samples Sl_*;
//               slave modport samples OPB_* and drives Sl_*.
// Revision    : 1.0 - initial release
// ============================================================================
interface opb_register_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface
`default_nettype wire

// File: rtl/opb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : opb_register_bank
// Description : Bank of N_REGS 32-bit user registers on an OPB slave port.
//               A three-state handshake (IDLE -> ACK -> DONE) acknowledges
//               each hit for exactly one cycle. Writes commit byte-wise at
//               the end of the ACK cycle and raise a one-cycle strobe for
//               the target register. Registers flagged in PULSE_MASK keep a
//               written value for PULSE_LEN cycles and then clear to zero.
// Ports       : OPB_Clk        - clock, rising edge
//               OPB_Rst_n      - asynchronous active-low reset
//               opb            - OPB slave bus (address/data/handshake)
//               user_data_out  - register i on bits [32*i+31:32*i]
//               user_wr_stb    - one-cycle write strobe per register
// Revision    : 1.0 - initial release
// ============================================================================
module opb_register_bank #(
  parameter logic [31:0]       C_BASEADDR   = 32'h0100E200,
  parameter logic [31:0]       C_HIGHADDR   = 32'h0100E2FF,
  parameter int                C_OPB_AWIDTH = 32,
  parameter int                C_OPB_DWIDTH = 32,
  parameter int                N_REGS       = 4,
  parameter logic [N_REGS-1:0] PULSE_MASK   = '0,
  parameter int                PULSE_LEN    = 1,
  parameter logic [31:0]       INIT_VAL     = 32'h0
) (
  input  wire logic              OPB_Clk,
  input  wire logic              OPB_Rst_n,
  opb_register_bank_if.slave     opb,
  output logic [N_REGS*32-1:0]   user_data_out,
  output logic [N_REGS-1:0]      user_wr_stb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic                      r_ack;
  logic                      r_rnw;
  logic                      r_valid;   // index lies inside the bank
  logic [3:0]                r_idx;
  logic [0:3]                r_be;
  logic [C_OPB_DWIDTH-1:0]   r_data;
  logic [N_REGS-1:0]         r_stb;

  logic [C_OPB_AWIDTH-1:0]   w_offset;
  logic                      w_hit;
  logic                      w_in_range;
  logic                      w_commit;
  logic [N_REGS-1:0]         w_sel;
  logic [31:0]               w_regs [N_REGS];
  logic [31:0]               w_rd_data;
  logic                      w_unused;

  // Address decode. The offset is only meaningful when the address is
  // inside the window; words past N_REGS are acknowledged but inert.
  assign w_hit      = opb.OPB_select &&
                      (opb.OPB_ABus >= C_BASEADDR) &&
                      (opb.OPB_ABus <= C_HIGHADDR);
  assign w_offset   = opb.OPB_ABus - C_BASEADDR;
  assign w_in_range = (w_offset[31:2] < 30'(N_REGS));

  // Sequential hint and byte offset within a word carry no information here.
  assign w_unused = ^{opb.OPB_seqAddr, w_offset[1:0]};

  // Handshake: the request is captured on the hit edge so the ACK cycle
  // works from stable copies even if the master changes the bus.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_rnw   <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= 4'd0;
      r_be    <= 4'b0000;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            r_rnw   <= opb.OPB_RNW;
            r_valid <= w_in_range;
            r_idx   <= w_offset[5:2];
            r_be    <= opb.OPB_BE;
            r_data  <= opb.OPB_DBus;
          end
        end
        ST_ACK: begin
          r_state <= ST_DONE;
          r_ack   <= 1'b0;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign w_commit = (r_state == ST_ACK) && !r_rnw && r_valid;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_stb <= '0;
    end else begin
      r_stb <= w_sel;
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    logic [31:0] r_val;
    logic [31:0] w_merged;

    assign w_sel[i] = w_commit && (r_idx == 4'(i));

    // BE[k] owns DBus[8k:8k+7], which lands on register bits [31-8k -: 8].
    always_comb begin
      w_merged = r_val;
      for (int k = 0; k < 4; k++) begin
        if (r_be[k]) begin
          w_merged[31-8*k -: 8] = r_data[31-8*k -: 8];
        end
      end
    end

    if (PULSE_MASK[i]) begin : g_pulse
      logic [7:0] r_cnt;

      // A write restarts the count even on the edge that would have cleared
      // the value, so back-to-back writes never produce a zero gap.
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
          r_val <= 32'h0;
          r_cnt <= 8'd0;
        end else if (w_sel[i]) begin
          r_val <= w_merged;
          r_cnt <= 8'(PULSE_LEN);
        end else if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_val <= 32'h0;
          end
        end
      end
    end else begin : g_level
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
          r_val <= INIT_VAL;
        end else if (w_sel[i]) begin
          r_val <= w_merged;
        end
      end
    end

    assign w_regs[i]                 = r_val;
    assign user_data_out[32*i +: 32] = r_val;
  end

  always_comb begin
    w_rd_data = 32'h0;
    for (int i = 0; i < N_REGS; i++) begin
      if (r_idx == 4'(i)) begin
        w_rd_data = w_regs[i];
      end
    end
  end

  // Read data is gated so the bus carries zero outside the ACK cycle.
  assign opb.Sl_DBus    = (r_state == ST_ACK && r_rnw && r_valid) ? w_rd_data : 32'h0;
  assign opb.Sl_xferAck = r_ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_wr_stb    = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_opb_register_bank
// Description : Directed self-checking bench for opb_register_bank with
//               N_REGS=4, PULSE_MASK=0001, PULSE_LEN=3, INIT_VAL=A5A50000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opb_register_bank;
  localparam logic [31:0] BASE = 32'h0100E200;
  localparam logic [31:0] INIT = 32'hA5A50000;
  localparam logic [127:0] RST_UDO = {INIT, INIT, INIT, 32'h0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  opb_register_bank_if bus();
  logic [127:0] udo;
  logic [3:0]   stb;

  opb_register_bank #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (32'h0100E2FF),
    .N_REGS     (4),
    .PULSE_MASK (4'b0001),
    .PULSE_LEN  (3),
    .INIT_VAL   (INIT)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst_n     (rst_n),
    .opb           (bus),
    .user_data_out (udo),
    .user_wr_stb   (stb)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic rnw,
                       input logic [31:0] d, input logic [0:3] be);
    bus.OPB_select = 1'b1;
    bus.OPB_ABus   = a;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = d;
    bus.OPB_BE     = be;
  endtask

  task automatic idle_bus;
    bus.OPB_select = 1'b0;
    bus.OPB_ABus   = 32'h0;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_DBus   = 32'h0;
    bus.OPB_BE     = 4'b0000;
  endtask

  initial begin
    idle_bus();
    bus.OPB_seqAddr = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ack",   {127'h0, bus.Sl_xferAck}, 128'h0);
    chk("rst_dbus",  {96'h0, bus.Sl_DBus}, 128'h0);
    chk("rst_stb",   {124'h0, stb}, 128'h0);
    chk("rst_udo",   udo, RST_UDO);
    chk("rst_tied",  {125'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 128'h0);
    rst_n = 1'b1;
    tick();

    // Full-word write to reg 1
    drive(BASE + 32'h4, 1'b0, 32'hDEADBEEF, 4'b1111);
    #1 chk("w1_ack_pre", {127'h0, bus.Sl_xferAck}, 128'h0);
    tick();
    chk("w1_ack",    {127'h0, bus.Sl_xferAck}, 128'h1);
    chk("w1_dbus",   {96'h0, bus.Sl_DBus}, 128'h0);
    idle_bus();
    tick();
    chk("w1_ack_end", {127'h0, bus.Sl_xferAck}, 128'h0);
    chk("w1_udo",    udo, {INIT, INIT, 32'hDEADBEEF, 32'h0});
    chk("w1_stb",    {124'h0, stb}, {124'h0, 4'b0010});
    tick();
    chk("w1_stb_end", {124'h0, stb}, 128'h0);

    // Single lane write: BE[2] owns DBus[16:23] -> reg bits [15:8]
    drive(BASE + 32'h4, 1'b0, 32'h11223344, 4'b0010);
    tick();
    idle_bus();
    tick();
    chk("w2_udo",    udo, {INIT, INIT, 32'hDEAD33EF, 32'h0});
    chk("w2_stb",    {124'h0, stb}, {124'h0, 4'b0010});
    tick();

    // Readback of reg 1
    drive(BASE + 32'h4, 1'b1, 32'h0, 4'b1111);
    #1 chk("r1_dbus_pre", {96'h0, bus.Sl_DBus}, 128'h0);
    tick();
    chk("r1_ack",    {127'h0, bus.Sl_xferAck}, 128'h1);
    chk("r1_dbus",   {96'h0, bus.Sl_DBus}, {96'h0, 32'hDEAD33EF});
    idle_bus();
    tick();
    chk("r1_dbus_post", {96'h0, bus.Sl_DBus}, 128'h0);
    chk("r1_stb",    {124'h0, stb}, 128'h0);
    tick();

    // Pulse register 0: holds 3 cycles after commit, then clears
    drive(BASE, 1'b0, 32'h1, 4'b1111);
    tick();
    idle_bus();
    tick();
    chk("p1_c1", {96'h0, udo[31:0]}, 128'h1);
    chk("p1_stb", {124'h0, stb}, {124'h0, 4'b0001});
    tick();
    chk("p1_c2", {96'h0, udo[31:0]}, 128'h1);
    tick();
    chk("p1_c3", {96'h0, udo[31:0]}, 128'h1);
    tick();
    chk("p1_clr", {96'h0, udo[31:0]}, 128'h0);
    tick();

    // Pulse rewrite landing on the expiry edge merges and restarts the count.
    // The request is raised during DONE, which must not be accepted.
    drive(BASE, 1'b0, 32'h1, 4'b1111);
    tick();
    idle_bus();
    tick();                                   // commit edge C
    chk("p2_c1", {96'h0, udo[31:0]}, 128'h1);
    drive(BASE, 1'b0, 32'h00000200, 4'b0010);
    tick();                                   // C+1: DONE -> IDLE
    chk("p2_done_noack", {127'h0, bus.Sl_xferAck}, 128'h0);
    chk("p2_c2", {96'h0, udo[31:0]}, 128'h1);
    tick();                                   // C+2: hit accepted
    chk("p2_ack", {127'h0, bus.Sl_xferAck}, 128'h1);
    chk("p2_c3", {96'h0, udo[31:0]}, 128'h1);
    idle_bus();
    tick();                                   // C+3: rewrite commits
    chk("p2_merge1", {96'h0, udo[31:0]}, {96'h0, 32'h00000201});
    tick();
    chk("p2_merge2", {96'h0, udo[31:0]}, {96'h0, 32'h00000201});
    tick();
    chk("p2_merge3", {96'h0, udo[31:0]}, {96'h0, 32'h00000201});
    tick();
    chk("p2_clr", {96'h0, udo[31:0]}, 128'h0);

    // Expired pulse register reads back zero
    drive(BASE, 1'b1, 32'h0, 4'b1111);
    tick();
    chk("p_rd_ack",  {127'h0, bus.Sl_xferAck}, 128'h1);
    chk("p_rd_dbus", {96'h0, bus.Sl_DBus}, 128'h0);
    idle_bus();
    tick(); tick();

    // Index beyond N_REGS inside the window
    drive(BASE + 32'h20, 1'b1, 32'h0, 4'b1111);
    tick();
    chk("oob_r_ack",  {127'h0, bus.Sl_xferAck}, 128'h1);
    chk("oob_r_dbus", {96'h0, bus.Sl_DBus}, 128'h0);
    idle_bus();
    tick(); tick();
    drive(BASE + 32'h20, 1'b0, 32'hFFFFFFFF, 4'b1111);
    tick();
    chk("oob_w_ack", {127'h0, bus.Sl_xferAck}, 128'h1);
    chk("oob_w_err", {127'h0, bus.Sl_errAck}, 128'h0);
    idle_bus();
    tick();
    chk("oob_w_stb", {124'h0, stb}, 128'h0);
    chk("oob_w_udo", udo, {INIT, INIT, 32'hDEAD33EF, 32'h0});
    tick();

    // Outside the window: just above and just below
    drive(BASE + 32'h100, 1'b1, 32'h0, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hi_noack", {127'h0, bus.Sl_xferAck}, 128'h0);
      chk("hi_dbus",  {96'h0, bus.Sl_DBus}, 128'h0);
    end
    drive(BASE - 32'h4, 1'b0, 32'hFFFFFFFF, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("lo_noack", {127'h0, bus.Sl_xferAck}, 128'h0);
    end
    idle_bus();
    tick();
    chk("lo_udo", udo, {INIT, INIT, 32'hDEAD33EF, 32'h0});
    chk("lo_stb", {124'h0, stb}, 128'h0);

    // Reset asserted inside the ACK cycle of a write to reg 2
    drive(BASE + 32'h8, 1'b0, 32'hFFFFFFFF, 4'b1111);
    tick();
    chk("ra_ack", {127'h0, bus.Sl_xferAck}, 128'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_ack_clr", {127'h0, bus.Sl_xferAck}, 128'h0);
    chk("ra_dbus",    {96'h0, bus.Sl_DBus}, 128'h0);
    chk("ra_stb",     {124'h0, stb}, 128'h0);
    chk("ra_udo",     udo, RST_UDO);
    idle_bus();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ra_post_stb", {124'h0, stb}, 128'h0);
    chk("ra_post_udo", udo, RST_UDO);

    // First hit after release is serviced normally
    drive(BASE + 32'h8, 1'b0, 32'h12345678, 4'b1111);
    tick();
    chk("rr_ack", {127'h0, bus.Sl_xferAck}, 128'h1);
    idle_bus();
    tick();
    chk("rr_udo", udo, {INIT, 32'h12345678, INIT, 32'h0});
    chk("rr_stb", {124'h0, stb}, {124'h0, 4'b0100});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
